beep_sequencer: RTL and testbench

Controller that shares the single board buzzer between up to NUM_REQ requesters, typically the debounced key-press pulses from the key filters. Each requester is served with its own beep pattern: source i produces i+1 beeps. Requests are latched as pending, arbitrated round-robin, and played one complete pattern at a time. A silent guard gap separates consecutive patterns. The block sits between the key debounce logic and the beep pin in the top level.

---
 rtl/beep_sequencer.sv | 158 +++++++++++++++
 tb/tb_beep_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/beep_sequencer.sv
// beep_sequencer
//
// Shares one buzzer between NUM_REQ requesters. Source i plays i+1 beeps of
// ON_CYC cycles separated by OFF_CYC silent cycles, followed by a GAP_CYC
// silent guard gap. Requests are latched as pending, arbitrated round-robin
// starting after the last granted source, and played one pattern at a time.
//
// Ports:
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset (aborts any pattern)
//   req        in   [NUM_REQ]  single-cycle request pulses, one per source
//   beep       out  buzzer drive, registered, high only while in ON
//   busy       out  high whenever the sequencer is not IDLE
//   grant_id   out  source being served; holds its value while IDLE
//   pending    out  [NUM_REQ] latched requests not yet served
//   state_dbg  out  [2] current FSM state (IDLE=0, ON=1, OFF=2, GAP=3)
//
// Handshake: req is a fire-and-forget pulse with no ready/backpressure; a
// pulse is always captured into pending on the edge that samples it, and a
// pulse on an already-pending source is absorbed (requests are not counted).

module beep_sequencer #(
    parameter int NUM_REQ = 4,
    parameter int ON_CYC  = 5_000_000,
    parameter int OFF_CYC = 5_000_000,
    parameter int GAP_CYC = 15_000_000
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic [NUM_REQ-1:0]         req,
    output logic                       beep,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [NUM_REQ-1:0]         pending,
    output logic [1:0]                 state_dbg
);

    localparam int GW      = $clog2(NUM_REQ);
    localparam int MAX_ON  = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int MAX_CYC = (MAX_ON > GAP_CYC) ? MAX_ON : GAP_CYC;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    // beeps_left must hold NUM_REQ (the largest pattern)
    localparam int BW      = $clog2(NUM_REQ + 1);

    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYC - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [BW-1:0]   beeps_left, beeps_n;
    logic [GW-1:0]   grant_n;
    logic [GW-1:0]   last_grant, last_n;
    logic [NUM_REQ-1:0] clr;

    logic            found;
    logic [GW-1:0]   sel;
    logic [BW-1:0]   beeps_dec;

    // Round-robin pick: first pending source searching upward from
    // last_grant+1 with wrap-around.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && pending[(int'(last_grant) + k) % NUM_REQ]) begin
                found = 1'b1;
                sel   = GW'((int'(last_grant) + k) % NUM_REQ);
            end
        end
    end

    assign beeps_dec = beeps_left - BW'(1);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        beeps_n = beeps_left;
        grant_n = grant_id;
        last_n  = last_grant;
        clr     = '0;
        case (state)
            S_IDLE: begin
                if (found) begin
                    grant_n   = sel;
                    last_n    = sel;
                    beeps_n   = BW'(sel) + BW'(1);
                    clr[sel]  = 1'b1;
                    cnt_n     = ON_LOAD;
                    state_n   = S_ON;
                end
            end
            S_ON: begin
                if (cnt == '0) begin
                    beeps_n = beeps_dec;
                    if (beeps_dec != '0) begin
                        cnt_n   = OFF_LOAD;
                        state_n = S_OFF;
                    end else begin
                        cnt_n   = GAP_LOAD;
                        state_n = S_GAP;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_OFF: begin
                if (cnt == '0) begin
                    cnt_n   = ON_LOAD;
                    state_n = S_ON;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            beeps_left <= '0;
            grant_id   <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            pending    <= '0;
            beep       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            beeps_left <= beeps_n;
            grant_id   <= grant_n;
            last_grant <= last_n;
            // A new request on the bit being cleared wins: the source is
            // queued again rather than lost.
            pending    <= (pending & ~clr) | req;
            beep       <= (state_n == S_ON);
        end
    end

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_beep_sequencer.sv
module tb_beep_sequencer;

    localparam int NR  = 4;
    localparam int ONC = 4;
    localparam int OFC = 3;
    localparam int GPC = 6;

    logic          sys_clk;
    logic          sys_rst_n;
    logic [NR-1:0] req;
    logic          beep;
    logic          busy;
    logic [1:0]    grant_id;
    logic [NR-1:0] pending;
    logic [1:0]    state_dbg;

    int checks = 0;
    int errors = 0;

    beep_sequencer #(
        .NUM_REQ(NR), .ON_CYC(ONC), .OFF_CYC(OFC), .GAP_CYC(GPC)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req       (req),
        .beep      (beep),
        .busy      (busy),
        .grant_id  (grant_id),
        .pending   (pending),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // ---------------- reference model ----------------
    // Each grant expands into a flat per-cycle list of (beep, busy) slots:
    // the whole pattern plus its trailing IDLE cycle. A new grant is only
    // possible when the list is empty.
    typedef struct packed { logic b; logic bz; } slot_t;
    slot_t         plan_q[$];
    logic [NR-1:0] m_pend;
    int            m_last;
    logic [1:0]    m_grant;
    logic          m_beep;
    logic          m_busy;
    bit            model_cmp = 1'b0;

    task automatic model_reset();
        plan_q.delete();
        m_pend  = '0;
        m_last  = NR - 1;
        m_grant = '0;
        m_beep  = 1'b0;
        m_busy  = 1'b0;
    endtask

    task automatic model_step(input logic [NR-1:0] r);
        slot_t s;
        int    g;
        if (plan_q.size() == 0 && m_pend != '0) begin
            g = -1;
            for (int k = 1; k <= NR; k++)
                if (g < 0 && m_pend[(m_last + k) % NR]) g = (m_last + k) % NR;
            m_pend[g] = 1'b0;
            m_grant   = 2'(g);
            m_last    = g;
            for (int p = 0; p <= g; p++) begin
                repeat (ONC) plan_q.push_back('{b: 1'b1, bz: 1'b1});
                if (p < g) repeat (OFC) plan_q.push_back('{b: 1'b0, bz: 1'b1});
            end
            repeat (GPC) plan_q.push_back('{b: 1'b0, bz: 1'b1});
            plan_q.push_back('{b: 1'b0, bz: 1'b0});
        end
        m_pend = m_pend | r;
        if (plan_q.size() > 0) begin
            s      = plan_q.pop_front();
            m_beep = s.b;
            m_busy = s.bz;
        end else begin
            m_beep = 1'b0;
            m_busy = 1'b0;
        end
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-pattern observations: grant_id and pending at each busy rise,
    // and the number of beep pulses in each pattern.
    logic [1:0]    seen_grant[$];
    logic [NR-1:0] seen_pend[$];
    int            seen_pulses[$];
    logic          prev_busy = 1'b0;
    logic          prev_beep = 1'b0;

    task automatic clear_obs();
        seen_grant.delete();
        seen_pend.delete();
        seen_pulses.delete();
    endtask

    // One clock cycle: drive at negedge, model at posedge, sample at negedge.
    task automatic cycle(input logic [NR-1:0] r);
        req = r;
        @(posedge sys_clk);
        model_step(r);
        @(negedge sys_clk);
        if (busy && !prev_busy) begin
            seen_grant.push_back(grant_id);
            seen_pend.push_back(pending);
            seen_pulses.push_back(0);
        end
        if (beep && !prev_beep && seen_pulses.size() > 0)
            seen_pulses[seen_pulses.size()-1]++;
        prev_busy = busy;
        prev_beep = beep;
        if (model_cmp) begin
            chk("model_beep", 32'(beep), 32'(m_beep));
            chk("model_busy", 32'(busy), 32'(m_busy));
            chk("model_grant", 32'(grant_id), 32'(m_grant));
            chk("model_pending", 32'(pending), 32'(m_pend));
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        req       = '0;
        model_reset();
        repeat (2) @(negedge sys_clk);
        chk("rst_beep", 32'(beep), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        sys_rst_n = 1'b1;
        prev_busy = 1'b0;
        prev_beep = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [NR-1:0] r;
        logic [NR-1:0] pend;
        logic          b;
        logic          bz;
        logic [1:0]    g;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input int n, input logic [NR-1:0] r, input logic [NR-1:0] pend,
                       input logic b, input logic bz, input logic [1:0] g);
        vec_t v;
        v.r = r; v.pend = pend; v.b = b; v.bz = bz; v.g = g;
        repeat (n) vecs.push_back(v);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        req       = '0;
        model_reset();

        // Source 0 alone: one 4-cycle beep, 6-cycle gap, one IDLE cycle.
        add(1, 4'b0001, 4'b0001, 0, 0, 2'd0);
        add(ONC, 4'b0000, 4'b0000, 1, 1, 2'd0);
        add(GPC, 4'b0000, 4'b0000, 0, 1, 2'd0);
        add(1, 4'b0000, 4'b0000, 0, 0, 2'd0);
        // Source 2 alone: three beeps, 24 busy cycles in total.
        add(1, 4'b0100, 4'b0100, 0, 0, 2'd0);
        add(ONC, 4'b0000, 4'b0000, 1, 1, 2'd2);
        add(OFC, 4'b0000, 4'b0000, 0, 1, 2'd2);
        add(ONC, 4'b0000, 4'b0000, 1, 1, 2'd2);
        add(OFC, 4'b0000, 4'b0000, 0, 1, 2'd2);
        add(ONC, 4'b0000, 4'b0000, 1, 1, 2'd2);
        add(GPC, 4'b0000, 4'b0000, 0, 1, 2'd2);
        add(1, 4'b0000, 4'b0000, 0, 0, 2'd2);

        // Reset then 50 quiet cycles.
        do_reset();
        for (int i = 0; i < 50; i++) begin
            cycle('0);
            chk("idle_beep", 32'(beep), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_pending", 32'(pending), 32'd0);
            chk("idle_grant", 32'(grant_id), 32'd0);
        end

        // Table vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].r);
            chk($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].pend));
            chk($sformatf("vec%0d_beep", i), 32'(beep), 32'(vecs[i].b));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].bz));
            chk($sformatf("vec%0d_grant", i), 32'(grant_id), 32'(vecs[i].g));
        end

        // Three simultaneous requests: order 0,1,3 with 1,2,4 pulses.
        model_cmp = 1'b1;
        do_reset();
        clear_obs();
        cycle(4'b1011);
        chk("multi_pend_req", 32'(pending), 32'(4'b1011));
        repeat (80) cycle('0);
        chk("multi_npat", seen_grant.size(), 3);
        if (seen_grant.size() == 3) begin
            chk("multi_g0", 32'(seen_grant[0]), 32'd0);
            chk("multi_g1", 32'(seen_grant[1]), 32'd1);
            chk("multi_g2", 32'(seen_grant[2]), 32'd3);
            chk("multi_p0", 32'(seen_pend[0]), 32'(4'b1010));
            chk("multi_p1", 32'(seen_pend[1]), 32'(4'b1000));
            chk("multi_p2", 32'(seen_pend[2]), 32'(4'b0000));
            chk("multi_n0", seen_pulses[0], 1);
            chk("multi_n1", seen_pulses[1], 2);
            chk("multi_n2", seen_pulses[2], 4);
        end

        // Two re-requests of source 1 while it plays: served once more only.
        do_reset();
        clear_obs();
        cycle(4'b0010);
        cycle(4'b0000);
        chk("rereq_beep_on", 32'(beep), 32'd1);
        cycle(4'b0010);
        cycle(4'b0000);
        cycle(4'b0010);
        chk("rereq_pend", 32'(pending), 32'(4'b0010));
        repeat (60) cycle('0);
        chk("rereq_npat", seen_grant.size(), 2);
        if (seen_grant.size() == 2) begin
            chk("rereq_g1", 32'(seen_grant[1]), 32'd1);
            chk("rereq_n0", seen_pulses[0], 2);
            chk("rereq_n1", seen_pulses[1], 2);
        end
        chk("rereq_end_pend", 32'(pending), 32'd0);

        // Asynchronous reset in the middle of an ON phase.
        do_reset();
        clear_obs();
        cycle(4'b1001);
        cycle(4'b0000);
        chk("abort_pend", 32'(pending), 32'(4'b1000));
        chk("abort_beep_on", 32'(beep), 32'd1);
        cycle(4'b0000);
        sys_rst_n = 1'b0;
        #1;
        chk("abort_beep_async", 32'(beep), 32'd0);
        chk("abort_busy_async", 32'(busy), 32'd0);
        chk("abort_pend_async", 32'(pending), 32'd0);
        model_reset();
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        prev_busy = 1'b0;
        prev_beep = 1'b0;
        clear_obs();
        repeat (30) cycle('0);
        chk("abort_no_pattern", seen_grant.size(), 0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 11) == 0) cycle(4'($urandom_range(1, 15)));
            else cycle('0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
